// File: rtl/delay_value_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_value_sink_if
// Purpose  : Bus bundle between the delay-path sink FIFO and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface delay_value_sink_if #(
  parameter int AW = 3
);
  logic [33:0]   VDin;
  logic          VDinValid;
  logic [33:0]   VDout;
  logic          VDoutValid;
  logic          VDoutReady;
  logic          Full;
  logic          Empty;
  logic [AW:0]   Level;
  logic [15:0]   OvfCount;
  logic          OvfClear;

  modport master (
    output VDin, VDinValid, VDoutReady, OvfClear,
    input  VDout, VDoutValid, Full, Empty, Level, OvfCount
  );

  modport slave (
    input  VDin, VDinValid, VDoutReady, OvfClear,
    output VDout, VDoutValid, Full, Empty, Level, OvfCount
  );
endinterface
`default_nettype wire

// File: rtl/delay_value_sink.sv
`default_nettype none
// ============================================================================
// Module   : delay_value_sink
// Purpose  : Show-ahead FIFO buffering 34-bit delay-path words for a
//            ready/valid consumer, with a saturating overflow counter.
// Revision : 1.0 - initial release
// ============================================================================
module delay_value_sink #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input wire                Clock,
  input wire                Reset,
  delay_value_sink_if.slave bus
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [33:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;

  logic w_full, w_empty, w_push, w_pop, w_ovf;

  // Status comes from the level counter so a full FIFO is never
  // confused with an empty one when the pointers coincide.
  assign w_full  = (level_q == c_depth);
  assign w_empty = (level_q == '0);
  assign w_pop   = !w_empty && bus.VDoutReady;
  assign w_push  = bus.VDinValid && (!w_full || w_pop);
  assign w_ovf   = bus.VDinValid && w_full && !w_pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_cnt_d = ovf_cnt_q;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (w_push && !w_pop)      level_d = level_q + 1'b1;
    else if (w_pop && !w_push) level_d = level_q - 1'b1;

    // Clear wins over a same-cycle overflow.
    if (bus.OvfClear)                         ovf_cnt_d = '0;
    else if (w_ovf && ovf_cnt_q != 16'hFFFF)  ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage is deliberately not reset; the level counter masks stale entries.
  always_ff @(posedge Clock) begin
    if (w_push && !Reset) mem_q[wr_ptr_q] <= bus.VDin;
  end

  assign bus.VDout      = mem_q[rd_ptr_q] & {34{!w_empty}};
  assign bus.VDoutValid = !w_empty;
  assign bus.Full       = w_full;
  assign bus.Empty      = w_empty;
  assign bus.Level      = level_q;
  assign bus.OvfCount   = ovf_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_value_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_value_sink
// Purpose  : Scoreboard bench for the delay-path sink FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_value_sink;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic Clock;
  logic Reset;

  delay_value_sink_if #(.AW(AW)) bus ();

  delay_value_sink #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          errors = 0;
  int          checks = 0;
  logic [33:0] sb[$];
  logic [15:0] m_ovf = 16'h0;
  logic [33:0] last_pop;

  // One clock of stimulus; the model decides push/pop/overflow from its own
  // state, and every word the consumer takes is compared against the queue.
  task automatic step(input logic v, input logic [33:0] d, input logic rdy, input logic clr);
    bit m_full, m_pop, m_push;
    bus.VDinValid  = v;
    bus.VDin       = d;
    bus.VDoutReady = rdy;
    bus.OvfClear   = clr;
    m_full = (sb.size() == DEPTH);
    m_pop  = (sb.size() > 0) && rdy;
    if (m_pop) begin
      checks++;
      if (bus.VDoutValid !== 1'b1 || bus.VDout !== sb[0]) begin
        errors++;
        $display("FAIL sb_pop: got valid=%b data=%h, need valid=1 data=%h",
                 bus.VDoutValid, bus.VDout, sb[0]);
      end
      last_pop = bus.VDout;
      void'(sb.pop_front());
    end
    m_push = v && (!m_full || m_pop);
    if (m_push) sb.push_back(d);
    if (clr) m_ovf = 16'h0;
    else if (v && m_full && !m_pop && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
    @(posedge Clock);
    #1;
    bus.VDinValid = 1'b0;
    bus.OvfClear  = 1'b0;
  endtask

  task automatic do_reset(input int n, input logic v, input logic [33:0] d);
    for (int i = 0; i < n; i++) begin
      Reset         = 1'b1;
      bus.VDinValid = v;
      bus.VDin      = d;
      @(posedge Clock);
      #1;
      checks++;
      if (bus.Level !== '0) begin
        errors++;
        $display("FAIL reset_level_hold: got %0d, need 0", bus.Level);
      end
    end
    Reset         = 1'b0;
    bus.VDinValid = 1'b0;
    sb.delete();
    m_ovf = 16'h0;
  endtask

  task automatic test_reset();
    do_reset(2, 1'b1, 34'h3_FFFF_FFFF);
    checks++;
    if (bus.Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, need 1", bus.Empty); end
    checks++;
    if (bus.Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, need 0", bus.Full); end
    checks++;
    if (bus.Level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d, need 0", bus.Level); end
    checks++;
    if (bus.VDoutValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, need 0", bus.VDoutValid); end
    checks++;
    if (bus.VDout !== 34'h0) begin errors++; $display("FAIL reset_vdout: got %h, need 0", bus.VDout); end
    checks++;
    if (bus.OvfCount !== 16'h0) begin errors++; $display("FAIL reset_ovf: got %h, need 0", bus.OvfCount); end
    // A couple of idle cycles must not change anything.
    step(1'b0, 34'h0, 1'b1, 1'b0);
    step(1'b0, 34'h0, 1'b1, 1'b0);
    checks++;
    if (bus.Level !== 4'd0) begin errors++; $display("FAIL idle_level: got %0d, need 0", bus.Level); end
  endtask

  task automatic test_streaming();
    int max_level = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 34'(i), 1'b1, 1'b0);
      checks++;
      if (bus.VDoutValid !== 1'b1 || bus.VDout !== 34'(i)) begin
        errors++;
        $display("FAIL stream_latency: got valid=%b data=%h, need valid=1 data=%h",
                 bus.VDoutValid, bus.VDout, 34'(i));
      end
      if (int'(bus.Level) > max_level) max_level = int'(bus.Level);
    end
    step(1'b0, 34'h0, 1'b1, 1'b0);
    checks++;
    if (max_level > 1) begin errors++; $display("FAIL stream_level: got max %0d, need <=1", max_level); end
    checks++;
    if (bus.Empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b, need 1", bus.Empty); end
    checks++;
    if (bus.OvfCount !== 16'h0) begin errors++; $display("FAIL stream_ovf: got %h, need 0", bus.OvfCount); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 34'(i), 1'b0, 1'b0);
      if (i == 7) begin
        checks++;
        if (bus.Full !== 1'b0) begin errors++; $display("FAIL fill_full7: got %b, need 0", bus.Full); end
      end
      if (i == 8) begin
        checks++;
        if (bus.Full !== 1'b1 || bus.Level !== 4'd8) begin
          errors++;
          $display("FAIL fill_full8: got full=%b level=%0d, need full=1 level=8", bus.Full, bus.Level);
        end
      end
    end
    checks++;
    if (bus.OvfCount !== 16'd4) begin errors++; $display("FAIL fill_ovf: got %0d, need 4", bus.OvfCount); end
    for (int i = 0; i < DEPTH && sb.size() > 0; i++) step(1'b0, 34'h0, 1'b1, 1'b0);
    checks++;
    if (last_pop !== 34'h8) begin errors++; $display("FAIL fill_last: got %h, need 8", last_pop); end
    checks++;
    if (bus.Empty !== 1'b1 || bus.VDout !== 34'h0) begin
      errors++;
      $display("FAIL fill_drained: got empty=%b vdout=%h, need empty=1 vdout=0", bus.Empty, bus.VDout);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] ovf_before;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 34'h100 + 34'(i), 1'b0, 1'b0);
    ovf_before = m_ovf;
    step(1'b1, 34'h2_0000_0055, 1'b1, 1'b0);
    checks++;
    if (bus.Level !== 4'd8 || bus.Full !== 1'b1) begin
      errors++;
      $display("FAIL fpp_level: got level=%0d full=%b, need level=8 full=1", bus.Level, bus.Full);
    end
    checks++;
    if (bus.OvfCount !== ovf_before) begin
      errors++;
      $display("FAIL fpp_ovf: got %0d, need %0d", bus.OvfCount, ovf_before);
    end
    for (int i = 0; i < DEPTH && sb.size() > 0; i++) step(1'b0, 34'h0, 1'b1, 1'b0);
    checks++;
    if (last_pop !== 34'h2_0000_0055) begin errors++; $display("FAIL fpp_last: got %h, need 200000055", last_pop); end
    checks++;
    if (bus.Empty !== 1'b1) begin errors++; $display("FAIL fpp_empty: got %b, need 1", bus.Empty); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 34'h200 + 34'(i), 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, 34'h3_0000_0000, 1'b0, 1'b0);
    checks++;
    if (bus.OvfCount !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %h, need FFFF", bus.OvfCount); end
    step(1'b1, 34'h3_0000_0001, 1'b0, 1'b1);
    checks++;
    if (bus.OvfCount !== 16'h0) begin errors++; $display("FAIL sat_clear: got %h, need 0", bus.OvfCount); end
    step(1'b1, 34'h3_0000_0002, 1'b0, 1'b0);
    checks++;
    if (bus.OvfCount !== 16'h1) begin errors++; $display("FAIL sat_after_clear: got %h, need 1", bus.OvfCount); end
    for (int i = 0; i < DEPTH && sb.size() > 0; i++) step(1'b0, 34'h0, 1'b1, 1'b0);
    checks++;
    if (last_pop !== 34'h207) begin errors++; $display("FAIL sat_drain_last: got %h, need 207", last_pop); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 34'h1_0000_0000 + 34'(i), 1'b0, 1'b0);
    checks++;
    if (bus.Level !== 4'd5) begin errors++; $display("FAIL mid_level5: got %0d, need 5", bus.Level); end
    do_reset(1, 1'b0, 34'h0);
    checks++;
    if (bus.Empty !== 1'b1 || bus.Level !== 4'd0 || bus.VDoutValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got empty=%b level=%0d valid=%b, need 1/0/0",
               bus.Empty, bus.Level, bus.VDoutValid);
    end
    step(1'b1, 34'hA, 1'b0, 1'b0);
    step(1'b1, 34'hB, 1'b0, 1'b0);
    checks++;
    if (bus.Level !== 4'd2 || bus.VDout !== 34'hA) begin
      errors++;
      $display("FAIL mid_refill: got level=%0d head=%h, need level=2 head=a", bus.Level, bus.VDout);
    end
    step(1'b0, 34'h0, 1'b1, 1'b0);
    step(1'b0, 34'h0, 1'b1, 1'b0);
    checks++;
    if (last_pop !== 34'hB || bus.Empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain: got last=%h empty=%b, need last=b empty=1", last_pop, bus.Empty);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset          = 1'b1;
    bus.VDin       = 34'h0;
    bus.VDinValid  = 1'b0;
    bus.VDoutReady = 1'b0;
    bus.OvfClear   = 1'b0;
    last_pop       = 34'h0;
    @(posedge Clock);
    #1;
    test_reset();
    test_streaming();
    test_fill_overflow();
    test_full_push_pop();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_value_sink.md
# delay_value_sink

Receiving end of the 34-bit value delay path: captures words arriving from the fixed-latency delay chain with a valid strobe, buffers them in a small FIFO, and presents them to the downstream consumer (DAC/output formatter) over a ready/valid handshake. Downstream stalls no longer lose samples while the FIFO has space. Overflows are counted rather than silently discarded.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- AW, 3: log2(DEPTH); must match DEPTH.
- Clock  in  1  single clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- VDin  in  34  value word from the delay path output.
- VDinValid  in  1  VDin carries a word this cycle; no backpressure upstream.
- VDout  out  34  head-of-FIFO word (show-ahead); 34'h0 whenever Empty.
- VDoutValid  out  1  head word present; equals !Empty.
- VDoutReady  in  1  consumer takes the word when VDoutValid & VDoutReady.
- Full  out  1  Level == DEPTH.
- Empty  out  1  Level == 0.
- Level  out  AW+1  current occupancy, 0..DEPTH.
- OvfCount  out  16  dropped-word counter, saturating at 16'hFFFF.
- OvfClear  in  1  synchronous clear of OvfCount.

## Operation
- Storage: DEPTH x 34 register array, write pointer and read pointer (AW bits each, natural wrap), plus an explicit Level counter. Full and Empty are decoded from Level, never from pointer equality.
- Push = VDinValid & (!Full | Pop). Pop = VDoutValid & VDoutReady.
- Push writes VDin at the write pointer, and the write pointer increments modulo DEPTH.
- Pop increments the read pointer modulo DEPTH.
- Level update:
  - Push only: +1.
  - Pop only: -1.
  - Both or neither: unchanged.
- Simultaneous push and pop while full: both happen, Level stays DEPTH, and no overflow is counted.
- Simultaneous push and pop while empty: Pop is impossible because VDoutValid is 0. The push happens and Level becomes 1.
- Overflow: VDinValid & Full & !Pop. The word is dropped, the FIFO is untouched, and OvfCount increments unless it is already 16'hFFFF.
- OvfClear: OvfCount becomes 0 on the next edge. Clear takes priority over a same-cycle overflow, so the count is 0, not 1.
- VDout is the array entry at the read pointer, ANDed with {34{!Empty}}. It is combinational from registered state only; there is no combinational path from VDin or VDoutReady to any output.
- Reset:
  - Clears pointers, Level and OvfCount. Array contents are not cleared.
  - Any VDinValid word in the reset cycle is discarded.
  - Asserting Reset mid-stream discards all buffered words.
- Words carry no interpretation here. All 34 bits pass through bit-exact and in order.

## Timing
- Reset values (after the edge with Reset=1):
  - Level=0, Empty=1, Full=0.
  - VDoutValid=0, VDout=34'h0.
  - OvfCount=0.
- Push-to-output latency:
  - A word pushed at edge N into an empty FIFO is on VDout with VDoutValid=1 immediately after edge N, i.e. usable in cycle N+1.
  - Minimum latency from VDinValid to VDoutValid is 1 cycle.
- Pop: when Pop is high in cycle N, the next word (or Empty) appears after edge N+1.
- Throughput: 1 word/cycle sustained with VDoutReady held high. Level stays at 0 or 1 and is never full.
- Full, Empty and Level are registered-state decodes and are valid in the same cycle as VDout.

## Test plan
- **Reset then idle:** assert Reset 2 cycles, release.
  - Response: Empty=1, Level=0, VDout=0, OvfCount=0.
  - Hold VDinValid=1 with VDin=34'h3_FFFF_FFFF during the reset cycle; Level must stay 0.
- **Streaming:** VDoutReady=1, push 34'h000000001..34'h000000010 on consecutive cycles.
  - Response: identical sequence on VDout, each 1 cycle after its push.
  - Level never exceeds 1; OvfCount=0.
- **Fill and overflow:** VDoutReady=0, push 12 words 34'h1..34'hC (DEPTH=8).
  - Response: Full after the 8th push, OvfCount=4.
  - Draining yields exactly 34'h1..34'h8, then Empty.
- **Full push/pop:** fill to 8, then one cycle with VDinValid=1 (34'h2_0000_0055) and VDoutReady=1.
  - Response: Level stays 8, OvfCount unchanged.
  - The drained sequence ends with 34'h2_0000_0055.
- **Counter saturation and clear:** force 65,540 overflow cycles.
  - Response: OvfCount=16'hFFFF.
  - OvfClear together with an overflow cycle gives 0; the next overflow gives 1.
- **Reset mid-operation:** with Level=5, pulse Reset for 1 cycle.
  - Response: Empty=1, Level=0, VDoutValid=0.
  - Subsequent pushes 34'hA, 34'hB are read back as 34'hA, 34'hB with no stale data.
